seq_cla_divider: RTL and testbench
==================================

Name: seq_cla_divider

Overview:
- Multi-cycle unsigned restoring divider; the inverse operation of the team's carry-lookahead adders.
- Each iteration does one trial subtraction, partial remainder minus divisor.
- The subtraction is built as an add with the divisor inverted and carry-in forced to 1. It uses a (WIDTH+1)-bit carry-lookahead adder from the team's mpfa/mclg4 adder cells.
- Sits beside the arithmetic datapath and serves divide requests through a start/busy/done handshake.

Parameters:
- WIDTH, 16, operand width. Legal values are 8 and 16 only; any other value is an elaboration error.

Ports:
- clk  input  1  single system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request strobe, sampled only in IDLE
- Dividend  input  WIDTH  numerator, captured when start is accepted
- Divisor  input  WIDTH  denominator, captured when start is accepted
- busy  output  1  high from the cycle after acceptance until done
- done  output  1  one-cycle pulse when results become valid
- Quotient  output  WIDTH  result quotient
- Remainder  output  WIDTH  result remainder
- DivByZero  output  1  high when the captured Divisor was 0; valid with done

Behaviour:
- Interface (already decided): one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE; busy=0, done=0, Quotient=0, Remainder=0, DivByZero=0. All internal registers clear.
- State IDLE:
  - busy=0.
  - On start=1, capture Dividend into Q register and Divisor into D register.
  - Clear partial remainder R (WIDTH+1 bits), clear DivByZero, load iteration counter = WIDTH.
  - If the captured Divisor==0, go to DIVZ; otherwise go to RUN.
- State RUN (busy=1), one iteration per cycle:
  - Shift {R,Q} left by 1.
  - T = R_shifted + ~{1'b0,D} + 1, computed by the CLA, with carry-out C.
  - If C=1 (no borrow): R=T[WIDTH:0] and quotient LSB=1. Otherwise R stays R_shifted and quotient LSB=0.
  - Decrement the counter. When it reaches 0 after this update, go to FIN.
- State DIVZ (busy=1), one cycle:
  - Quotient = all ones, Remainder = captured Dividend, DivByZero=1.
  - Then go to FIN.
- State FIN, one cycle:
  - done=1, busy=0.
  - Quotient/Remainder outputs update from Q and R[WIDTH-1:0] (skipped in DIVZ, where they were already written).
  - Then go to IDLE.
- Latency:
  - Start accepted at edge 0; done high in the cycle following edge WIDTH+1 (17 cycles for WIDTH=16).
  - Divide-by-zero: done after edge 2.
- Result holding: Quotient, Remainder and DivByZero hold their values after done until the next accepted start. They do not change during a new operation's RUN; they update only in FIN or DIVZ.
- start while busy or during FIN is ignored: no capture, no restart.
- start held high continuously re-triggers only on IDLE cycles. Back-to-back throughput is one operation per WIDTH+2 cycles.
- Operand changes after acceptance have no effect.
- Arithmetic:
  - R carries one extra bit so the shifted remainder never overflows.
  - Invariant: Dividend == Quotient*Divisor + Remainder, with Remainder < Divisor, for all Divisor != 0.
- rst asserted at any point, including mid-RUN, forces IDLE and the reset values immediately. No done pulse follows for the aborted operation.

Test Plan:
- WIDTH=16, Dividend=100, Divisor=7, start for 1 cycle -> busy for 16+ cycles; done pulses 17 cycles after acceptance; Quotient=14, Remainder=2, DivByZero=0.
- Dividend=16'hFFFF, Divisor=1 -> Quotient=16'hFFFF, Remainder=0. Then Dividend=16'hFFFF, Divisor=16'hFFFF -> Quotient=1, Remainder=0.
- Dividend=3, Divisor=10 -> Quotient=0, Remainder=3. Dividend=0, Divisor=5 -> Quotient=0, Remainder=0.
- Dividend=16'h1234, Divisor=0 -> done after 2 cycles; Quotient=16'hFFFF, Remainder=16'h1234, DivByZero=1. The next valid divide clears DivByZero.
- Start 1000/3, then pulse start with 50/5 at cycle 5 -> ignored; result Quotient=333, Remainder=1. Outputs hold those values until the next accepted start.
- Assert rst at cycle 8 of a run -> busy=0, done=0, outputs 0 immediately; no done pulse. A new start afterwards completes correctly.
- 2000 random Divisor != 0 pairs at WIDTH=8 and WIDTH=16 -> quotient and remainder invariant holds and latency is exact.

Source files
------------

// File: rtl/seq_cla_divider.sv
// Multi-cycle unsigned restoring divider. Each RUN cycle does one trial
// subtraction R - D through a carry-lookahead adder built from mpfa/mclg4 cells.

module seq_cla_mpfa (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic p,
  output logic g
);
  assign p = a ^ b;
  assign g = a & b;
  assign s = p ^ c;
endmodule

module seq_cla_mclg4 (
  input  logic [3:0] p,
  input  logic [3:0] g,
  input  logic       ci,
  output logic [3:0] co
);
  // co[i] is the carry into bit i+1 of the group
  assign co[0] = g[0] | (p[0] & ci);
  assign co[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign co[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
  assign co[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & ci);
endmodule

module seq_cla_adder #(
  parameter int N = 17
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] s,
  output logic         co
);
  localparam int NG = (N + 3) / 4;
  localparam int NP = NG * 4;

  logic [NP-1:0] ap, bp, sp, p, g;
  logic [NP:0]   c;
  logic          unused_pad;

  assign ap   = NP'(a);
  assign bp   = NP'(b);
  assign c[0] = ci;

  for (genvar i = 0; i < NP; i++) begin : g_fa
    seq_cla_mpfa u_fa (.a(ap[i]), .b(bp[i]), .c(c[i]), .s(sp[i]), .p(p[i]), .g(g[i]));
  end

  // groups chained carry-to-carry
  for (genvar k = 0; k < NG; k++) begin : g_lg
    seq_cla_mclg4 u_lg (.p(p[4*k +: 4]), .g(g[4*k +: 4]), .ci(c[4*k]), .co(c[4*k+1 +: 4]));
  end

  assign s          = sp[N-1:0];
  assign co         = c[N];
  assign unused_pad = ^{sp[NP-1:N], c[NP:N+1]};
endmodule

module seq_cla_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             DivByZero
);
  if (WIDTH != 8 && WIDTH != 16) begin : g_bad_width
    $error("seq_cla_divider: WIDTH must be 8 or 16");
  end

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DIVZ = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d, d_q, d_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d;
  logic             dz_q, dz_d, done_q, done_d;

  logic [WIDTH:0]   r_sh, t;
  logic             c_out;
  logic             unused_msb;

  // R[WIDTH] is always 0 after a restore, so the shift drops it
  assign r_sh       = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
  assign unused_msb = r_q[WIDTH];

  seq_cla_adder #(.N(WIDTH + 1)) u_sub (
    .a  (r_sh),
    .b  (~{1'b0, d_q}),
    .ci (1'b1),
    .s  (t),
    .co (c_out)
  );

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    d_d     = d_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        q_d     = Dividend;
        d_d     = Divisor;
        r_d     = '0;
        dz_d    = 1'b0;
        cnt_d   = CW'(WIDTH);
        state_d = (Divisor == '0) ? S_DIVZ : S_RUN;
      end
      S_RUN: begin
        q_d   = {q_q[WIDTH-2:0], c_out};
        r_d   = c_out ? t : r_sh;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = S_FIN;
      end
      S_DIVZ: begin
        quo_d   = '1;
        rem_d   = q_q;
        dz_d    = 1'b1;
        state_d = S_FIN;
      end
      default: begin
        done_d = 1'b1;
        if (!dz_q) begin
          quo_d = q_q;
          rem_d = r_q[WIDTH-1:0];
        end
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      d_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      d_q     <= d_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
    end
  end

  assign busy      = (state_q == S_RUN) || (state_q == S_DIVZ);
  assign done      = done_q;
  assign Quotient  = quo_q;
  assign Remainder = rem_q;
  assign DivByZero = dz_q;
endmodule

// File: tb/tb_seq_cla_divider.sv
// Bench for seq_cla_divider at WIDTH=16 and WIDTH=8: directed table,
// multi-cycle corner sequences and random pairs checked through scoreboards.

module tb_seq_cla_divider;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        st16 = 1'b0, st8 = 1'b0;
  logic [15:0] dvd16 = '0, dvs16 = '0, q16, r16;
  logic [7:0]  dvd8 = '0, dvs8 = '0, q8, r8;
  logic        busy16, done16, dz16, busy8, done8, dz8;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [15:0] a, b, q, r;
    logic        dz;
    int          lat;
  } vec_t;

  typedef struct {
    logic [15:0] q, r;
    logic        dz;
    int          acc, lat;
  } exp_t;

  exp_t sb16[$];
  exp_t sb8[$];
  exp_t e16, e8;
  vec_t vt[8];

  seq_cla_divider #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .start(st16), .Dividend(dvd16), .Divisor(dvs16),
    .busy(busy16), .done(done16), .Quotient(q16), .Remainder(r16), .DivByZero(dz16)
  );

  seq_cla_divider #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(st8), .Dividend(dvd8), .Divisor(dvs8),
    .busy(busy8), .done(done8), .Quotient(q8), .Remainder(r8), .DivByZero(dz8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) if (done16) begin
    if (sb16.size() == 0) begin
      checks++; errors++;
      $display("FAIL done16_spurious got done=1 want 0 (cycle %0d)", cyc);
    end else begin
      e16 = sb16.pop_front();
      chk("q16", q16, e16.q);
      chk("r16", r16, e16.r);
      chk("dz16", dz16, e16.dz);
      chk("lat16", cyc - e16.acc, e16.lat);
    end
  end

  always @(negedge clk) if (done8) begin
    if (sb8.size() == 0) begin
      checks++; errors++;
      $display("FAIL done8_spurious got done=1 want 0 (cycle %0d)", cyc);
    end else begin
      e8 = sb8.pop_front();
      chk("q8", q8, e8.q);
      chk("r8", r8, e8.r);
      chk("dz8", dz8, e8.dz);
      chk("lat8", cyc - e8.acc, e8.lat);
    end
  end

  task automatic go16(input logic [15:0] a, b, eq, er, input logic edz, input int lat);
    @(negedge clk);
    dvd16 = a; dvs16 = b; st16 = 1'b1;
    @(posedge clk); #1;
    sb16.push_back('{q: eq, r: er, dz: edz, acc: cyc, lat: lat});
    st16 = 1'b0;
    chk("busy16_after_accept", busy16, 1);
  endtask

  task automatic wait16();
    for (int i = 0; i < 40 && sb16.size() != 0; i++) @(posedge clk);
    if (sb16.size() != 0) begin
      checks++; errors++;
      $display("FAIL timeout16 got no done want done within 40 cycles");
      sb16.delete();
    end
  endtask

  task automatic go8(input logic [7:0] a, b);
    @(negedge clk);
    dvd8 = a; dvs8 = b; st8 = 1'b1;
    @(posedge clk); #1;
    sb8.push_back('{q: 16'(a / b), r: 16'(a % b), dz: 1'b0, acc: cyc, lat: 9});
    st8 = 1'b0;
  endtask

  task automatic wait8();
    for (int i = 0; i < 30 && sb8.size() != 0; i++) @(posedge clk);
    if (sb8.size() != 0) begin
      checks++; errors++;
      $display("FAIL timeout8 got no done want done within 30 cycles");
      sb8.delete();
    end
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic [7:0]  ra8, rb8;

    vt[0] = '{a: 16'd100,   b: 16'd7,     q: 16'd14,    r: 16'd2,     dz: 1'b0, lat: 17};
    vt[1] = '{a: 16'hFFFF,  b: 16'd1,     q: 16'hFFFF,  r: 16'd0,     dz: 1'b0, lat: 17};
    vt[2] = '{a: 16'hFFFF,  b: 16'hFFFF,  q: 16'd1,     r: 16'd0,     dz: 1'b0, lat: 17};
    vt[3] = '{a: 16'd3,     b: 16'd10,    q: 16'd0,     r: 16'd3,     dz: 1'b0, lat: 17};
    vt[4] = '{a: 16'd0,     b: 16'd5,     q: 16'd0,     r: 16'd0,     dz: 1'b0, lat: 17};
    vt[5] = '{a: 16'h1234,  b: 16'd0,     q: 16'hFFFF,  r: 16'h1234,  dz: 1'b1, lat: 2};
    vt[6] = '{a: 16'd40000, b: 16'd200,   q: 16'd200,   r: 16'd0,     dz: 1'b0, lat: 17};
    vt[7] = '{a: 16'd65534, b: 16'd32768, q: 16'd1,     r: 16'd32766, dz: 1'b0, lat: 17};

    repeat (3) @(negedge clk);
    chk("rst_busy", busy16, 0);
    chk("rst_done", done16, 0);
    chk("rst_q", q16, 0);
    chk("rst_r", r16, 0);
    chk("rst_dz", dz16, 0);
    chk("rst_q8", q8, 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      go16(vt[i].a, vt[i].b, vt[i].q, vt[i].r, vt[i].dz, vt[i].lat);
      wait16();
    end

    // start and operand changes during RUN are ignored
    go16(16'd1000, 16'd3, 16'd333, 16'd1, 1'b0, 17);
    repeat (4) @(negedge clk);
    dvd16 = 16'd50; dvs16 = 16'd5; st16 = 1'b1;
    @(negedge clk);
    st16 = 1'b0;
    wait16();
    repeat (5) @(negedge clk);
    chk("hold_q", q16, 333);
    chk("hold_r", r16, 1);
    go16(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 17);
    repeat (8) @(negedge clk);
    chk("run_hold_q", q16, 333);
    chk("run_hold_r", r16, 1);
    wait16();

    // reset mid-run aborts without a done pulse
    @(negedge clk);
    dvd16 = 16'd1000; dvs16 = 16'd3; st16 = 1'b1;
    @(posedge clk); #1;
    st16 = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", busy16, 0);
    chk("abort_done", done16, 0);
    chk("abort_q", q16, 0);
    chk("abort_r", r16, 0);
    chk("abort_dz", dz16, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    go16(16'd1000, 16'd3, 16'd333, 16'd1, 1'b0, 17);
    wait16();

    for (int i = 0; i < 2000; i++) begin
      ra  = 16'($urandom);
      rb  = (i % 2 == 0) ? 16'($urandom_range(1, 65535)) : 16'($urandom_range(1, 255));
      ra8 = 8'($urandom_range(0, 255));
      rb8 = 8'($urandom_range(1, 255));
      fork
        begin
          go16(ra, rb, ra / rb, ra % rb, 1'b0, 17);
          wait16();
        end
        begin
          go8(ra8, rb8);
          wait8();
        end
      join
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
